timer_sequencer: RTL
====================

# timer_sequencer

Master-side controller for the sequential timer. It holds a small table of interval lengths and, on a `go_i` command, launches the timer once per table entry in order, optionally looping. It drives the timer's start/length inputs and consumes its end pulse. Sits between a host-side config/control port and one timer instance.

## Interface
- `DEPTH`, 4, number of interval entries; power of two, 2..16
- `AW`, 2, entry address width, log2(DEPTH)
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cfg_we_i`  in  1  write entry strobe
- `cfg_addr_i`  in  AW  entry index to write
- `cfg_data_i`  in  16  interval length in cycles; 0 = skip entry
- `num_steps_i`  in  AW+1  entries per pass (1..DEPTH), sampled on accepted go
- `loop_i`  in  1  repeat passes until abort; sampled on accepted go
- `go_i`  in  1  start sequence (level, sampled per cycle)
- `abort_i`  in  1  stop sequence
- `timer_start_q`  out  1  to timer start input; one-cycle pulse per launch
- `timer_n_q`  out  16  to timer length input; held stable while timer runs
- `timer_end_i`  in  1  from timer end output
- `busy_q`  out  1  sequence or drain in progress
- `step_q`  out  AW  index of current entry
- `done_q`  out  1  one-cycle pulse: non-loop sequence completed
- `pass_cnt_q`  out  8  completed passes since accepted go, wraps 255->0

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN. Reset: state IDLE, table all 0, every output 0.
- Table writes: `cfg_we_i` writes `cfg_data_i` to entry `cfg_addr_i` only when `busy_q`=0; ignored when busy.
- IDLE: `go_i`=1 with 1 <= `num_steps_i` <= DEPTH -> latch num_steps/loop, `step_q`<=0, `pass_cnt_q`<=0, clear ran-flag, `busy_q`<=1, ->ISSUE. Otherwise go ignored.
- ISSUE: entry[step]!=0 -> `timer_n_q`<=entry, `timer_start_q`<=1, set ran-flag, ->WAIT. Entry==0 -> no launch, advance (below) in same cycle.
- WAIT: `timer_start_q`<=0. On `timer_end_i`=1 -> advance.
- Advance: step < num_steps-1 -> step+1, ->ISSUE. Last step: `pass_cnt_q`+1; if loop and ran-flag set -> step 0, clear ran-flag, ->ISSUE; else -> IDLE, `busy_q`<=0, `done_q`<=1 (loop with all-zero pass also ends this way).
- Abort (priority over all other events, any non-IDLE state): in ISSUE -> IDLE immediately, no launch. In WAIT: if `timer_end_i`=1 same cycle -> IDLE; else ->DRAIN. DRAIN waits for `timer_end_i`, then IDLE. No `done_q` on abort; `pass_cnt_q` not incremented.
- `busy_q` stays 1 through DRAIN; go ignored until IDLE.
- `timer_n_q` holds last launched value outside runs; never changes while in WAIT/DRAIN.

## Timing
- `go_i` accepted at edge k: ISSUE after k; `timer_start_q`=1 during cycle after k+1, exactly one cycle.
- Timer runs n cycles: `timer_end_i` high after edge k+2+n; sequencer advances at k+3+n.
- Back-to-back entries: 3-cycle gap from end pulse to next start pulse high (end seen, ISSUE, start).
- Skipped entry costs one ISSUE cycle.
- `done_q` high one cycle after edge following final `timer_end_i`; `busy_q` falls same edge.
- Reset asserted mid-sequence: all registers to reset values immediately; timer resets from same `rst_n`.

## Test plan
- Entry0=5, num_steps=1, loop=0, go at edge 0 -> start pulse after edge 1, timer end after edge 7, `done_q`=1 and `busy_q`=0 after edge 8, `pass_cnt_q`=1.
- Entries {3,0,2,4}, num_steps=4 -> three start pulses with `timer_n_q` 3,2,4; `step_q` sequence 0,1,2,3; entry 1 skipped in one cycle; one `done_q`.
- Loop=1, entries {2,2}, num_steps=2 -> continuous launches, `pass_cnt_q` increments every pass; abort mid-WAIT -> DRAIN until end, then IDLE, no `done_q`.
- All entries 0, loop=1, num_steps=4 -> no start pulses, `done_q` after 4 ISSUE cycles.
- Abort same cycle as `timer_end_i` -> IDLE next edge; `num_steps_i`=0 or >DEPTH go -> ignored, `busy_q` stays 0.
- Config write while busy -> table unchanged (verify on next run); `rst_n` low mid-WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/timer_sequencer.sv
// ---------------------------------------------------------------------------
// timer_sequencer
//
// Master-side controller for a sequential timer. A small table of interval
// lengths is loaded over the config port while idle. A go command launches
// the timer once per table entry in order (zero-length entries are skipped),
// optionally repeating whole passes until aborted.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_we_i          table write strobe (honoured only while not busy)
//   cfg_addr_i        table entry index
//   cfg_data_i        interval length in cycles, 0 = skip entry
//   num_steps_i       entries per pass (1..DEPTH), sampled on accepted go
//   loop_i            repeat passes until abort, sampled on accepted go
//   go_i              start command (level, sampled every cycle while idle)
//   abort_i           stop the running sequence
//   timer_start_q     one-cycle launch pulse to the timer
//   timer_n_q         interval length presented to the timer
//   timer_end_i       end pulse from the timer
//   busy_q            sequence or drain in progress
//   step_q            index of the current entry
//   done_q            one-cycle pulse when a non-looping sequence completes
//   pass_cnt_q        completed passes since the accepted go (wraps)
// ---------------------------------------------------------------------------
module timer_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we_i,
    input  logic [AW-1:0] cfg_addr_i,
    input  logic [15:0]   cfg_data_i,
    input  logic [AW:0]   num_steps_i,
    input  logic          loop_i,
    input  logic          go_i,
    input  logic          abort_i,
    output logic          timer_start_q,
    output logic [15:0]   timer_n_q,
    input  logic          timer_end_i,
    output logic          busy_q,
    output logic [AW-1:0] step_q,
    output logic          done_q,
    output logic [7:0]    pass_cnt_q
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   NS_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] STEP_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q;
    logic [15:0]   table_q [DEPTH];
    logic [AW:0]   num_steps_q;
    logic          loop_q;
    // Set once any entry of the current pass actually launched the timer;
    // a looping pass that launched nothing terminates instead of spinning.
    logic          ran_q;

    logic          go_ok;
    logic          last_step;
    logic [15:0]   cur_entry;

    // Result of "advance to the next entry", shared by the skip path in
    // ISSUE and the end-of-interval path in WAIT.
    state_t        state_adv_d;
    logic [AW-1:0] step_adv_d;
    logic [7:0]    pass_adv_d;
    logic          ran_adv_d;
    logic          finish_d;

    assign cur_entry = table_q[step_q];
    assign go_ok     = go_i && (num_steps_i != '0) && (num_steps_i <= DEPTH_W);
    assign last_step = ({1'b0, step_q} == (num_steps_q - NS_ONE));

    always_comb begin
        state_adv_d = ST_ISSUE;
        step_adv_d  = step_q + STEP_ONE;
        pass_adv_d  = pass_cnt_q;
        ran_adv_d   = ran_q;
        finish_d    = 1'b0;
        if (last_step) begin
            pass_adv_d = pass_cnt_q + 8'd1;
            if (loop_q && ran_q) begin
                step_adv_d = '0;
                ran_adv_d  = 1'b0;
            end else begin
                state_adv_d = ST_IDLE;
                step_adv_d  = step_q;
                finish_d    = 1'b1;
            end
        end
    end

    // Interval table: writable only while idle so a running sequence always
    // sees a consistent set of lengths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (cfg_we_i && !busy_q) begin
            table_q[cfg_addr_i] <= cfg_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            num_steps_q   <= '0;
            loop_q        <= 1'b0;
            ran_q         <= 1'b0;
            timer_start_q <= 1'b0;
            timer_n_q     <= '0;
            busy_q        <= 1'b0;
            step_q        <= '0;
            done_q        <= 1'b0;
            pass_cnt_q    <= '0;
        end else begin
            timer_start_q <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go_ok) begin
                        num_steps_q <= num_steps_i;
                        loop_q      <= loop_i;
                        step_q      <= '0;
                        pass_cnt_q  <= '0;
                        ran_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cur_entry != '0) begin
                        timer_n_q     <= cur_entry;
                        timer_start_q <= 1'b1;
                        ran_q         <= 1'b1;
                        state_q       <= ST_WAIT;
                    end else begin
                        state_q    <= state_adv_d;
                        step_q     <= step_adv_d;
                        pass_cnt_q <= pass_adv_d;
                        ran_q      <= ran_adv_d;
                        if (finish_d) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (abort_i) begin
                        // The timer is still running unless it ends right now;
                        // drain its end pulse so it is idle before the next go.
                        if (timer_end_i) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end else if (timer_end_i) begin
                        state_q    <= state_adv_d;
                        step_q     <= step_adv_d;
                        pass_cnt_q <= pass_adv_d;
                        ran_q      <= ran_adv_d;
                        if (finish_d) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (timer_end_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
